semafor_sched: RTL and testbench

- Mode scheduler in front of the two-way traffic-light controller; drives its 2-bit mode select.
- Combines pedestrian buttons, per-direction vehicle-sensor counts and a manual override into one mode decision.
- The mode changes only at a light-cycle boundary, marked by a one-clock wrap pulse from the light, so a running cycle is never disturbed.
- Mode codes: 00 normal split; 01 favour A (longer A green); 10 favour B (longer A red). Code 11 is never emitted.

---
 rtl/semafor_sched.sv | 165 ++++++++++++++++
 tb/tb_semafor_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/semafor_sched.sv
// Mode scheduler for the two-way traffic light.
// Pedestrian requests, vehicle-density counts and a manual override are merged
// into one 2-bit mode select. The select changes only at a light-cycle wrap.
//
// Handshake note: there is no valid/ready pair here. cycle_wrap is a one-clock
// strobe and acts as the sole "decide now" event. ped_ack_a/ped_ack_b are
// one-clock strobes issued the clock after the deciding wrap. They are not
// back-pressured.
module semafor_sched #(
  parameter int PED_HOLD    = 1,
  parameter int DENS_THRESH = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cycle_wrap,
  input  logic       ped_req_a,
  input  logic       ped_req_b,
  input  logic       veh_a,
  input  logic       veh_b,
  input  logic       manual_en,
  input  logic [1:0] manual_sel,
  output logic [1:0] sel_out,
  output logic       ped_ack_a,
  output logic       ped_ack_b,
  output logic [1:0] ped_pend,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_AUTO   = 2'd0,
    ST_PED_A  = 2'd1,
    ST_PED_B  = 2'd2,
    ST_MANUAL = 2'd3
  } state_t;

  // The comparison is wide enough for both the counter and the threshold,
  // plus one carry bit, so cnt + DENS_THRESH can never wrap.
  localparam int CMP_W = ((CNT_W > 8) ? CNT_W : 8) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [3:0]       HOLD_INIT = 4'(PED_HOLD);
  localparam logic [CMP_W-1:0] THRESH    = CMP_W'(DENS_THRESH);

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             ack_a_q, ack_b_q;
  logic             pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic             req_a_q, req_b_q;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [3:0]       hold_q, hold_d;
  logic             ptr_q, ptr_d;      // 0 = A was served last, 1 = B
  logic             rise_a, rise_b;
  logic             grant_a, grant_b;
  logic [CMP_W-1:0] cmp_a, cmp_b;
  logic             favour_a, favour_b;

  assign rise_a = ped_req_a & ~req_a_q;
  assign rise_b = ped_req_b & ~req_b_q;

  assign cmp_a    = CMP_W'(cnt_a_q);
  assign cmp_b    = CMP_W'(cnt_b_q);
  assign favour_a = (cmp_a >= (cmp_b + THRESH));
  assign favour_b = (cmp_b >= (cmp_a + THRESH));

  // Vehicle counters: saturate inside a window, restart at a wrap with the
  // wrap clock's own pulse so that pulse is not lost.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (cycle_wrap) begin
      cnt_a_d = CNT_W'(veh_a);
      cnt_b_d = CNT_W'(veh_b);
    end else begin
      if (veh_a && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + 1'b1;
      if (veh_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + 1'b1;
    end
  end

  // Mode decision FSM: next state, select, hold and pointer, evaluated only
  // in a wrap clock so a running light cycle is never disturbed.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (cycle_wrap) begin
      if (manual_en) begin
        state_d = ST_MANUAL;
        sel_d   = (manual_sel == 2'b11) ? 2'b00 : manual_sel;
        hold_d  = 4'd0;
      end else if (((state_q == ST_PED_A) || (state_q == ST_PED_B)) &&
                   (hold_q > 4'd1)) begin
        hold_d = hold_q - 4'd1;
      end else if (pend_a_q || pend_b_q) begin
        // With both pending, serve the side the pointer did not serve last.
        if (pend_a_q && (!pend_b_q || ptr_q)) begin
          grant_a = 1'b1;
          state_d = ST_PED_A;
          sel_d   = 2'b10;
          ptr_d   = 1'b0;
          hold_d  = HOLD_INIT;
        end else begin
          grant_b = 1'b1;
          state_d = ST_PED_B;
          sel_d   = 2'b01;
          ptr_d   = 1'b1;
          hold_d  = HOLD_INIT;
        end
      end else begin
        state_d = ST_AUTO;
        hold_d  = 4'd0;
        if (favour_a)      sel_d = 2'b01;
        else if (favour_b) sel_d = 2'b10;
        else               sel_d = 2'b00;
      end
    end
  end

  // Request latches: a button edge in the same clock as its own grant is
  // absorbed, because the grant serves the person already waiting.
  always_comb begin
    pend_a_d = grant_a ? 1'b0 : (pend_a_q | rise_a);
    pend_b_d = grant_b ? 1'b0 : (pend_b_q | rise_b);
  end

  // All scheduler state registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_AUTO;
      sel_q    <= 2'b00;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      req_a_q  <= 1'b0;
      req_b_q  <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      hold_q   <= 4'd0;
      ptr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      ack_a_q  <= grant_a;
      ack_b_q  <= grant_b;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      req_a_q  <= ped_req_a;
      req_b_q  <= ped_req_b;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      hold_q   <= hold_d;
      ptr_q    <= ptr_d;
    end
  end

  assign sel_out   = sel_q;
  assign ped_ack_a = ack_a_q;
  assign ped_ack_b = ack_b_q;
  assign ped_pend  = {pend_b_q, pend_a_q};
  assign state     = state_q;

endmodule

// File: tb/tb_semafor_sched.sv
// Bench for semafor_sched: directed scenarios followed by random traffic.
// A behavioural model of the scheduling rules predicts every output each clock.
module tb_semafor_sched;

  localparam int PED_HOLD    = 2;
  localparam int DENS_THRESH = 8;
  localparam int CNT_W       = 8;
  localparam int CNT_SAT     = 255;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic       cycle_wrap, ped_req_a, ped_req_b, veh_a, veh_b, manual_en;
  logic [1:0] manual_sel;
  logic [1:0] sel_out, ped_pend, state;
  logic       ped_ack_a, ped_ack_b;

  always #5 clk = ~clk;

  semafor_sched #(
    .PED_HOLD(PED_HOLD), .DENS_THRESH(DENS_THRESH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cycle_wrap(cycle_wrap),
    .ped_req_a(ped_req_a), .ped_req_b(ped_req_b),
    .veh_a(veh_a), .veh_b(veh_b),
    .manual_en(manual_en), .manual_sel(manual_sel),
    .sel_out(sel_out), .ped_ack_a(ped_ack_a), .ped_ack_b(ped_ack_b),
    .ped_pend(ped_pend), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int         m_cnt_a, m_cnt_b, m_hold;
  bit         m_pend_a, m_pend_b, m_prev_a, m_prev_b, m_last_b;
  bit         m_ack_a, m_ack_b;
  logic [1:0] m_sel, m_state;   // state: 0 auto, 1 ped A, 2 ped B, 3 manual

  task automatic model_clk();
    bit rise_a, rise_b, serve_a, serve_b;
    rise_a = ped_req_a && !m_prev_a;
    rise_b = ped_req_b && !m_prev_b;
    serve_a = 0;
    serve_b = 0;
    if (!reset_n) begin
      m_cnt_a = 0; m_cnt_b = 0; m_hold = 0;
      m_pend_a = 0; m_pend_b = 0; m_prev_a = 0; m_prev_b = 0; m_last_b = 0;
      m_ack_a = 0; m_ack_b = 0; m_sel = 2'd0; m_state = 2'd0;
      return;
    end
    if (cycle_wrap) begin
      if (manual_en) begin
        m_state = 2'd3;
        m_sel   = (manual_sel == 2'd3) ? 2'd0 : manual_sel;
        m_hold  = 0;
      end else if ((m_state == 2'd1 || m_state == 2'd2) && m_hold > 1) begin
        m_hold = m_hold - 1;
      end else if (m_pend_a || m_pend_b) begin
        if (m_pend_a && m_pend_b) serve_a = m_last_b;
        else                      serve_a = m_pend_a;
        serve_b = !serve_a;
        m_hold  = PED_HOLD;
        m_last_b = serve_b;
        m_state = serve_a ? 2'd1 : 2'd2;
        m_sel   = serve_a ? 2'd2 : 2'd1;
      end else begin
        m_state = 2'd0;
        m_hold  = 0;
        if (m_cnt_a >= m_cnt_b + DENS_THRESH)      m_sel = 2'd1;
        else if (m_cnt_b >= m_cnt_a + DENS_THRESH) m_sel = 2'd2;
        else                                       m_sel = 2'd0;
      end
      m_cnt_a = veh_a ? 1 : 0;
      m_cnt_b = veh_b ? 1 : 0;
    end else begin
      if (veh_a && m_cnt_a < CNT_SAT) m_cnt_a++;
      if (veh_b && m_cnt_b < CNT_SAT) m_cnt_b++;
    end
    m_ack_a  = serve_a;
    m_ack_b  = serve_b;
    m_pend_a = serve_a ? 1'b0 : (m_pend_a | rise_a);
    m_pend_b = serve_b ? 1'b0 : (m_pend_b | rise_b);
    m_prev_a = ped_req_a;
    m_prev_b = ped_req_b;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
  endtask

  task automatic check_model();
    check("sel_out",   8'(sel_out),   8'(m_sel));
    check("state",     8'(state),     8'(m_state));
    check("ped_ack_a", 8'(ped_ack_a), 8'(m_ack_a));
    check("ped_ack_b", 8'(ped_ack_b), 8'(m_ack_b));
    check("ped_pend",  8'(ped_pend),  8'({m_pend_b, m_pend_a}));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wrap_pulse();
    cycle_wrap = 1'b1;
    step();
    cycle_wrap = 1'b0;
  endtask

  task automatic pulses(input int na, input int nb);
    int n;
    n = (na > nb) ? na : nb;
    for (int i = 0; i < n; i++) begin
      veh_a = (i < na);
      veh_b = (i < nb);
      step();
    end
    veh_a = 1'b0;
    veh_b = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; cycle_wrap = 1'b0; ped_req_a = 1'b0; ped_req_b = 1'b0;
    veh_a = 1'b0; veh_b = 1'b0; manual_en = 1'b0; manual_sel = 2'd0;

    // Reset with inputs toggling.
    for (int i = 0; i < 6; i++) begin
      cycle_wrap = 1'($urandom); ped_req_a = 1'($urandom); ped_req_b = 1'($urandom);
      veh_a = 1'($urandom); veh_b = 1'($urandom); manual_en = 1'($urandom);
      manual_sel = 2'($urandom);
      step();
      check("rst_sel", 8'(sel_out), 8'd0);
      check("rst_state", 8'(state), 8'd0);
      check("rst_pend", 8'(ped_pend), 8'd0);
      check("rst_acks", 8'({ped_ack_b, ped_ack_a}), 8'd0);
    end
    cycle_wrap = 1'b0; ped_req_a = 1'b0; ped_req_b = 1'b0;
    veh_a = 1'b0; veh_b = 1'b0; manual_en = 1'b0; manual_sel = 2'd0;
    reset_n = 1'b1;

    // Pedestrian A: request, grant at wrap, hold for two wraps.
    idle(9);
    ped_req_a = 1'b1;
    step();
    check("pa_pend", 8'(ped_pend), 8'b01);
    idle(63);
    wrap_pulse();
    check("pa_sel", 8'(sel_out), 8'b10);
    check("pa_state", 8'(state), 8'd1);
    check("pa_ack", 8'(ped_ack_a), 8'd1);
    check("pa_pend0", 8'(ped_pend), 8'b00);
    step();
    check("pa_ack_pulse", 8'(ped_ack_a), 8'd0);
    ped_req_a = 1'b0;
    idle(10);
    wrap_pulse();
    check("pa_hold", 8'(sel_out), 8'b10);
    idle(10);
    wrap_pulse();
    check("pa_release", 8'(sel_out), 8'b00);
    check("pa_auto", 8'(state), 8'd0);

    // Both buttons together: B first, A after B's hold.
    ped_req_a = 1'b1; ped_req_b = 1'b1;
    step();
    check("both_pend", 8'(ped_pend), 8'b11);
    idle(5);
    wrap_pulse();
    check("both_first_b", 8'(sel_out), 8'b01);
    check("both_ack_b", 8'(ped_ack_b), 8'd1);
    idle(5);
    wrap_pulse();
    check("both_hold_b", 8'(sel_out), 8'b01);
    idle(5);
    wrap_pulse();
    check("both_then_a", 8'(sel_out), 8'b10);
    ped_req_a = 1'b0; ped_req_b = 1'b0;
    idle(3); wrap_pulse(); idle(3); wrap_pulse();
    check("both_done", 8'(state), 8'd0);

    // Density decisions.
    pulses(12, 3); wrap_pulse();
    check("dens_12_3", 8'(sel_out), 8'b01);
    pulses(11, 3); wrap_pulse();
    check("dens_11_3", 8'(sel_out), 8'b01);
    pulses(10, 3); wrap_pulse();
    check("dens_10_3", 8'(sel_out), 8'b00);
    pulses(3, 12); wrap_pulse();
    check("dens_3_12", 8'(sel_out), 8'b10);
    pulses(300, 0); wrap_pulse();
    check("dens_sat_a", 8'(sel_out), 8'b01);
    pulses(300, 250); wrap_pulse();
    check("dens_sat_close", 8'(sel_out), 8'b00);

    // Wrap-clock vehicle pulse carries into the next window.
    veh_b = 1'b1; wrap_pulse(); veh_b = 1'b0;
    pulses(0, 7); wrap_pulse();
    check("carry_b", 8'(sel_out), 8'b10);

    // Manual 11 during a PED_A hold.
    ped_req_a = 1'b1; step(); ped_req_a = 1'b0;
    wrap_pulse();
    check("man_ped_a", 8'(state), 8'd1);
    ped_req_b = 1'b1; step(); ped_req_b = 1'b0;
    manual_en = 1'b1; manual_sel = 2'b11; idle(3);
    check("man_no_early", 8'(state), 8'd1);
    wrap_pulse();
    check("man_sel", 8'(sel_out), 8'b00);
    check("man_state", 8'(state), 8'd3);
    check("man_pend", 8'(ped_pend), 8'b10);
    manual_sel = 2'b10; wrap_pulse();
    check("man_sel10", 8'(sel_out), 8'b10);
    manual_en = 1'b0; idle(2);
    check("man_hold_off", 8'(state), 8'd3);
    wrap_pulse();
    check("man_exit_b", 8'(sel_out), 8'b01);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset_n    = ($urandom_range(0, 599) != 0);
      cycle_wrap = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) ped_req_a = ~ped_req_a;
      if ($urandom_range(0, 19) == 0) ped_req_b = ~ped_req_b;
      veh_a      = ($urandom_range(0, 99) < 45);
      veh_b      = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 29) == 0) manual_en = ~manual_en;
      manual_sel = 2'($urandom_range(0, 3));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
